run_sequencer: RTL
==================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter AW, default 8: data-memory address width; load length is 2**AW bytes.
REQ-002 Parameter TMO, default 4096: run-phase cycle limit before timeout.
REQ-003 Reset is synchronous and active-high; one clock, all state updates on its rising edge.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  level; sampled only in IDLE; begins a load-run sequence.
REQ-007 in_valid  in  1  byte-stream data valid.
REQ-008 in_data  in  8  byte-stream data.
REQ-009 in_ready  out  1  byte-stream ready; a transfer occurs when in_valid and in_ready are both high.
REQ-010 mem_wr_en  out  1  data-memory write strobe.
REQ-011 mem_addr  out  AW  data-memory write address.
REQ-012 mem_dat  out  8  data-memory write data.
REQ-013 cpu_reset  out  1  drives processor reset.
REQ-014 cpu_init  out  1  drives processor init.
REQ-015 cpu_done  in  1  processor done flag.
REQ-016 busy  out  1  high in LOAD, RELEASE and RUN.
REQ-017 finished  out  1  high in DONE.
REQ-018 timeout  out  1  high in ERR.
REQ-019 cycles  out  16  run-phase cycle count.

Function
REQ-020 States: IDLE, LOAD, RELEASE, RUN, DONE, ERR.
REQ-021 IDLE: in_ready=0, cpu_reset=1; start=1 -> LOAD with address counter cleared to 0.
REQ-022 LOAD: in_ready=1, cpu_reset=1; each transfer sets mem_wr_en=1, mem_addr=counter, mem_dat=in_data in that same cycle (combinational, zero latency), then increments the counter.
REQ-023 LOAD: no transfer -> mem_wr_en=0, counter holds; stalls of any length are legal.
REQ-024 LOAD: the transfer at counter=2**AW-1 -> RELEASE; the counter wraps to 0 and is not reused.
REQ-025 RELEASE lasts exactly one cycle: cpu_reset=0, cpu_init=1, cycles cleared to 0, then -> RUN.
REQ-026 RUN: cpu_reset=0, cpu_init=0, cycles increments by 1 every cycle and saturates at 16'hFFFF.
REQ-027 RUN: cpu_done=1 -> DONE; cycles freezes and keeps the count from before that edge.
REQ-028 RUN: cycles reaching TMO with cpu_done=0 -> ERR; when both occur on the same edge, cpu_done wins (DONE).
REQ-029 DONE and ERR: cpu_reset=1, cycles held; start=0 -> IDLE; start held high stays in DONE/ERR.
REQ-030 Outside LOAD: mem_wr_en=0, in_ready=0; cpu_init=1 only in RELEASE.
REQ-031 Outside RUN: cpu_done is ignored.
REQ-032 start outside IDLE, DONE and ERR is ignored.

Reset
REQ-033 reset in any state, including mid-LOAD or mid-RUN, -> IDLE on the next edge.
REQ-034 Reset values:
- address counter=0, cycles=0
- cpu_reset=1, cpu_init=0
- mem_wr_en=0, in_ready=0
- busy=0, finished=0, timeout=0
REQ-035 A partially loaded memory is not cleared by reset; the next LOAD restarts at address 0.

Configuration
REQ-036 Macro RUN_SEQUENCER_TIMEOUT_EN.
- Defined: REQ-028 timeout is active.
- Undefined: no ERR transition, timeout is tied to 0, and RUN waits indefinitely for cpu_done.

Verification
REQ-037 Idle hold: reset, start=0 for 10 cycles -> in_ready=0, cpu_reset=1, no writes.
REQ-038 Full load, AW=8, in_valid constant, data=addr^8'h5A:
- exactly 256 writes, addr 0..255, data matching
- one RELEASE cycle with cpu_init=1, cpu_reset=0
REQ-039 Back-pressure: in_valid toggled 1-0-1 during LOAD -> writes only on valid cycles, with no gaps or duplicates in addresses.
REQ-040 Normal run: cpu_done asserted 37 cycles after RELEASE -> finished=1, cycles=37, cpu_reset=1; start=0 -> IDLE.
REQ-041 Timeout (macro defined), TMO=100, cpu_done held 0 -> timeout=1 with cycles=100; cpu_done and timeout on the same edge -> finished=1.
REQ-042 Mid-run reset: reset at cycles=20 -> IDLE next cycle with all outputs at reset values; a new start reloads from addr 0.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: loads a byte stream into processor data memory, releases the
// processor from reset for one init cycle, then supervises the run until the
// processor reports done (or, optionally, until a cycle limit expires).
//
// Build option: define RUN_SEQUENCER_TIMEOUT_EN to enable the run-phase
// timeout (RUN -> ERR after TMO cycles). Without it, timeout is tied low and
// RUN waits for cpu_done indefinitely.
//
// Timing notes:
//   - mem_wr_en / mem_addr / mem_dat follow the handshake in the same cycle,
//     so a transfer is written with zero latency.
//   - cycles counts completed RUN cycles. It is cleared on the edge that
//     leaves RELEASE. The edge that sees cpu_done does not add to it.
module run_sequencer #(
  parameter int AW  = 8,
  parameter int TMO = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dat,
  output logic          cpu_reset,
  output logic          cpu_init,
  input  logic          cpu_done,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [15:0]   cycles
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

`ifdef RUN_SEQUENCER_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [15:0]   CYC_MAX   = 16'hFFFF;
  localparam logic [31:0]   TMO_LIM   = 32'(TMO);

  state_t        state_r;
  state_t        state_next_s;
  logic [AW-1:0] addr_r;
  logic [15:0]   cycles_r;
  logic          xfer_s;
  logic          last_xfer_s;
  logic [31:0]   cyc_plus1_s;
  logic          tmo_hit_s;

  // A byte moves only while loading and the source offers one.
  assign xfer_s      = (state_r == ST_LOAD) && in_valid;
  assign last_xfer_s = xfer_s && (addr_r == ADDR_LAST);

  // The count this RUN cycle would advance to; timeout fires when it lands on TMO.
  assign cyc_plus1_s = {16'h0000, cycles_r} + 32'd1;
  assign tmo_hit_s   = TMO_EN && (cycles_r != CYC_MAX) && (cyc_plus1_s == TMO_LIM);

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; cpu_done takes priority over a coincident timeout.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (last_xfer_s) begin
          state_next_s = ST_RELEASE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        state_next_s = ST_RUN;
      end
      ST_RUN: begin
        if (cpu_done) begin
          state_next_s = ST_DONE;
        end else if (tmo_hit_s) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_ERR: begin
        if (!start) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ERR;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Load address counter: cleared when a sequence starts, advanced per transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= {AW{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      addr_r <= {AW{1'b0}};
    end else if (xfer_s) begin
      addr_r <= addr_r + ADDR_ONE;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Run-phase cycle counter: cleared leaving RELEASE, saturating count in RUN,
  // frozen on the cpu_done edge and in every other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_r <= 16'h0000;
    end else if (state_r == ST_RELEASE) begin
      cycles_r <= 16'h0000;
    end else if ((state_r == ST_RUN) && !cpu_done && (cycles_r != CYC_MAX)) begin
      cycles_r <= cycles_r + 16'd1;
    end else begin
      cycles_r <= cycles_r;
    end
  end

  // State-decoded control outputs; an unknown encoding holds the processor in reset.
  always_comb begin
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    cpu_init  = 1'b0;
    busy      = 1'b0;
    finished  = 1'b0;
    timeout   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cpu_reset = 1'b1;
      end
      ST_LOAD: begin
        in_ready  = 1'b1;
        cpu_reset = 1'b1;
        busy      = 1'b1;
      end
      ST_RELEASE: begin
        cpu_reset = 1'b0;
        cpu_init  = 1'b1;
        busy      = 1'b1;
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        busy      = 1'b1;
      end
      ST_DONE: begin
        finished = 1'b1;
      end
      ST_ERR: begin
        timeout = TMO_EN;
      end
      default: begin
        cpu_reset = 1'b1;
      end
    endcase
  end

  // Memory write port mirrors the handshake in the same cycle.
  always_comb begin
    mem_wr_en = xfer_s;
    mem_addr  = addr_r;
    if (xfer_s) begin
      mem_dat = in_data;
    end else begin
      mem_dat = 8'h00;
    end
  end

  assign cycles = cycles_r;

endmodule
